// File: rtl/contador_sequencial.sv
// contador_sequencial: free-running table-driven counter.
// Advances one table entry per rising clock edge and presents the current
// entry on a registered output. The default table is a plain 0..15 up-count.
// Reset assertion is asynchronous; its release passes through a 2-flop
// synchroniser so the first step happens on the 2nd rising edge after release.

module contador_sequencial #(
    parameter int                         WIDTH   = 4,
    parameter int                         SEQ_LEN = 16,
    parameter logic [SEQ_LEN*WIDTH-1:0]   SEQ     = 64'hFEDC_BA98_7654_3210
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    // Index register is clog2(SEQ_LEN) wide, never narrower than one bit.
    localparam int               IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [WIDTH-1:0] SEQ_FIRST = SEQ[WIDTH-1:0];

    // Reject table shapes the index logic cannot represent.
    if (SEQ_LEN < 1 || SEQ_LEN > 16 || WIDTH < 1) begin : g_badParams
        $fatal(1, "contador_sequencial: SEQ_LEN must be 1..16 and WIDTH >= 1");
    end

    logic [1:0]       r_relSync;
    logic [IDX_W-1:0] r_index;
    logic [WIDTH-1:0] r_count;

    logic             w_advance;
    logic             w_indexBad;
    logic [IDX_W-1:0] w_nextIndex;
    logic [WIDTH-1:0] w_nextCount;

    // Release synchroniser: cleared immediately by reset, fills with ones after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_relSync <= 2'b00;
        end else begin
            r_relSync <= {r_relSync[0], 1'b1};
        end
    end

    // Stage 0 lets the first step land on the 2nd edge; stage 1 is the settled copy that holds the enable.
    assign w_advance = r_relSync[0] | r_relSync[1];

    // Next index wraps at the last entry; out-of-range indices fall back to entry 0.
    always_comb begin
        w_nextIndex = '0;
        w_indexBad  = (int'(r_index) >= SEQ_LEN);
        if (!w_indexBad && (int'(r_index) < SEQ_LEN - 1)) begin
            w_nextIndex = r_index + 1'b1;
        end
    end

    // Look up the table entry for the index we are about to move to.
    always_comb begin
        w_nextCount = SEQ_FIRST;
        if (int'(w_nextIndex) < SEQ_LEN) begin
            w_nextCount = SEQ[int'(w_nextIndex)*WIDTH +: WIDTH];
        end
    end

    // Index and output move together so the output is always the entry of the current index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_index <= '0;
            r_count <= SEQ_FIRST;
        end else if (w_advance || w_indexBad) begin
            r_index <= w_nextIndex;
            r_count <= w_nextCount;
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_contador_sequencial.sv
// Testbench for contador_sequencial: drives a default-table instance and a
// 5-entry custom-table instance from the same clock and reset, with a
// behavioural model filling expected-value queues that are drained on each check.

module tb_contador_sequencial;

    localparam logic [3:0] TABLE_B [5] = '{4'd4, 4'd1, 4'd7, 4'd3, 4'd9};

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] countA;
    logic [3:0] countB;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] expQA[$];
    logic [3:0] expQB[$];

    int relEdges = 0;
    int idxA     = 0;
    int idxB     = 0;

    contador_sequencial dutA (
        .clk   (clk),
        .reset (reset),
        .count (countA)
    );

    contador_sequencial #(
        .WIDTH   (4),
        .SEQ_LEN (5),
        .SEQ     (20'h93714)
    ) dutB (
        .clk   (clk),
        .reset (reset),
        .count (countB)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [3:0] actual, input logic [3:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b at time %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        relEdges = 0;
        idxA     = 0;
        idxB     = 0;
    endtask

    task automatic pushExpected();
        expQA.push_back(4'(idxA));
        expQB.push_back(TABLE_B[idxB]);
    endtask

    task automatic popCompare(input string tag);
        logic [3:0] ea;
        logic [3:0] eb;
        ea = expQA.pop_front();
        eb = expQB.pop_front();
        checkOutput({tag, "_A"}, countA, ea);
        checkOutput({tag, "_B"}, countB, eb);
    endtask

    // Model one rising edge: reset holds the model at entry 0; after release
    // the first edge only fills the synchroniser, later edges step the table.
    task automatic modelEdge();
        if (!reset) begin
            modelReset();
        end else begin
            if (relEdges >= 1) begin
                idxA = (idxA + 1) % 16;
                idxB = (idxB + 1) % 5;
            end
            relEdges++;
        end
    endtask

    task automatic applyStimulus(input int edges, input string tag);
        for (int n = 0; n < edges; n++) begin
            @(posedge clk);
            modelEdge();
            pushExpected();
            #1;
            popCompare(tag);
        end
    endtask

    initial begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
        modelReset();
        #1;
        pushExpected();
        popCompare("rstAsync");

        // Held in reset: clock edges must not move the output.
        applyStimulus(5, "rstHold");

        // Release mid-period and watch the synchroniser delay then the count.
        #2;
        reset = 1'b1;
        applyStimulus(12, "count");

        // Long run through the wrap of both tables.
        applyStimulus(20, "wrap");

        // Advance until the default counter shows 0110, then drop reset mid-period.
        for (int n = 0; n < 20 && idxA != 6; n++) begin
            applyStimulus(1, "seek6");
        end
        checkOutput("at0110", countA, 4'b0110);
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        pushExpected();
        popCompare("midReset");
        applyStimulus(3, "lowHold");

        // Release one time unit before a rising edge.
        @(negedge clk);
        #4;
        reset = 1'b1;
        applyStimulus(6, "lateRelease");

        // Reset asserted on the same timestep as a rising edge: reset wins.
        @(posedge clk);
        reset = 1'b0;
        modelReset();
        #1;
        pushExpected();
        popCompare("edgeReset");
        applyStimulus(2, "edgeHold");

        // Final release: counting restarts from entry 0 with no remembered state.
        #3;
        reset = 1'b1;
        applyStimulus(8, "restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
